// File: rtl/note_pkg.sv
// Shared definitions for the note lane buffer: play-state encoding,
// lane colour indices and default geometry.
package note_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        PLAY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int RED    = 0;
    localparam int YELLOW = 1;
    localparam int BLUE   = 2;

    localparam int DEF_LANES = 3;
    localparam int DEF_DEPTH = 100;
    localparam int DEF_VIEW  = 27;

endpackage

// File: rtl/note_lane.sv
// One note lane: a DEPTH-bit shift register loaded from the song, shifted
// toward the exit column on each step, with judgement of the exit bit
// against the drum strike for that lane.
module note_lane #(
    parameter int DEPTH = 100,
    parameter int VIEW  = 27
) (
    input  logic             slow_clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic             hit,
    input  logic [DEPTH-1:0] song,
    output logic [VIEW-1:0]  view,
    output logic             judge_hit,
    output logic             judge_miss,
    output logic             hit_ok,
    output logic             miss
);

    logic [DEPTH-1:0] lane_reg;

    // Only a note sitting in the exit column is judged; empty exits ignore hit.
    assign judge_hit  = step &  lane_reg[DEPTH-1] &  hit;
    assign judge_miss = step &  lane_reg[DEPTH-1] & ~hit;

    assign view = lane_reg[DEPTH-1 -: VIEW];

    // Lane contents plus the one-cycle hit/miss pulses from the last judgement.
    always_ff @(posedge slow_clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_reg <= '0;
            hit_ok   <= 1'b0;
            miss     <= 1'b0;
        end else if (load) begin
            lane_reg <= song;
            hit_ok   <= 1'b0;
            miss     <= 1'b0;
        end else begin
            hit_ok <= judge_hit;
            miss   <= judge_miss;
            if (step)
                lane_reg <= lane_reg << 1;
        end
    end

endmodule

// File: rtl/note_lane_buffer.sv
// LANES note lanes scrolling toward an exit column while playing, with a
// play-state FSM, song-length countdown and saturating hit/miss totals.
module note_lane_buffer
    import note_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int DEPTH = DEF_DEPTH,
    parameter int VIEW  = DEF_VIEW,
    parameter int CNT_W = 8
) (
    input  logic                       slow_clk,
    input  logic                       reset_n,
    input  logic                       load,
    input  logic [LANES*DEPTH-1:0]     song_in,
    input  logic                       run,
    input  logic [LANES-1:0]           hit,
    output logic [LANES*VIEW-1:0]      view_out,
    output logic [LANES-1:0]           hit_ok,
    output logic [LANES-1:0]           miss,
    output logic [$clog2(DEPTH+1)-1:0] steps_left,
    output logic [CNT_W-1:0]           hit_cnt,
    output logic [CNT_W-1:0]           miss_cnt,
    output logic [1:0]                 state_o
);

    localparam int SW   = $clog2(DEPTH+1);
    localparam int PW   = $clog2(LANES+1);
    localparam int SUMW = CNT_W + PW;
    localparam logic [SUMW-1:0] CNT_MAX = {{PW{1'b0}}, {CNT_W{1'b1}}};

    state_t state_q, state_d;
    logic   step;

    logic [LANES-1:0] judge_hit, judge_miss;
    logic [PW-1:0]    hit_pop, miss_pop;
    logic [SUMW-1:0]  hit_sum, miss_sum;

    genvar l;
    generate
        for (l = 0; l < LANES; l++) begin : g_lane
            note_lane #(.DEPTH(DEPTH), .VIEW(VIEW)) u_lane (
                .slow_clk   (slow_clk),
                .reset_n    (reset_n),
                .load       (load),
                .step       (step),
                .hit        (hit[l]),
                .song       (song_in[l*DEPTH +: DEPTH]),
                .view       (view_out[l*VIEW +: VIEW]),
                .judge_hit  (judge_hit[l]),
                .judge_miss (judge_miss[l]),
                .hit_ok     (hit_ok[l]),
                .miss       (miss[l])
            );
        end
    endgenerate

    assign state_o = state_q;

    // Play-state register.
    always_ff @(posedge slow_clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state and step strobe; load wins over run and hit in any state.
    always_comb begin
        state_d = state_q;
        step    = 1'b0;
        if (load) begin
            state_d = READY;
        end else begin
            case (state_q)
                READY: if (run) state_d = PLAY;
                PLAY: begin
                    if (!run) begin
                        state_d = READY;
                    end else begin
                        step = 1'b1;
                        if (steps_left == SW'(1))
                            state_d = DONE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Count judged lanes this step and form saturating next totals.
    always_comb begin
        hit_pop  = '0;
        miss_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            hit_pop  = hit_pop  + PW'(judge_hit[i]);
            miss_pop = miss_pop + PW'(judge_miss[i]);
        end
        hit_sum  = {{PW{1'b0}}, hit_cnt}  + SUMW'(hit_pop);
        miss_sum = {{PW{1'b0}}, miss_cnt} + SUMW'(miss_pop);
        if (hit_sum > CNT_MAX)
            hit_sum = CNT_MAX;
        if (miss_sum > CNT_MAX)
            miss_sum = CNT_MAX;
    end

    // Song countdown and score totals.
    always_ff @(posedge slow_clk or negedge reset_n) begin
        if (!reset_n) begin
            steps_left <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else if (load) begin
            steps_left <= SW'(DEPTH);
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else if (step) begin
            steps_left <= steps_left - SW'(1);
            hit_cnt    <= hit_sum[CNT_W-1:0];
            miss_cnt   <= miss_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_note_lane_buffer.sv
// Directed bench for note_lane_buffer: default geometry plus a 2-bit
// counter instance for saturation.
module tb_note_lane_buffer;

    localparam int LANES = 3;
    localparam int DEPTH = 100;
    localparam int VIEW  = 27;
    localparam int SW    = $clog2(DEPTH+1);

    logic                   slow_clk = 1'b0;
    logic                   reset_n  = 1'b0;
    logic                   load     = 1'b0;
    logic [LANES*DEPTH-1:0] song_in  = '0;
    logic                   run      = 1'b0;
    logic [LANES-1:0]       hit      = '0;
    logic [LANES*VIEW-1:0]  view_out;
    logic [LANES-1:0]       hit_ok, miss;
    logic [SW-1:0]          steps_left;
    logic [7:0]             hit_cnt, miss_cnt;
    logic [1:0]             state_o;

    logic                   load2 = 1'b0;
    logic [LANES*DEPTH-1:0] song2 = '0;
    logic                   run2  = 1'b0;
    logic [LANES-1:0]       hit2  = '0;
    logic [LANES*VIEW-1:0]  view2;
    logic [LANES-1:0]       hit_ok2, miss2;
    logic [SW-1:0]          steps2;
    logic [1:0]             hit_cnt2, miss_cnt2;
    logic [1:0]             state2;

    int checks   = 0;
    int failures = 0;

    always #5 slow_clk = ~slow_clk;

    note_lane_buffer #(.LANES(LANES), .DEPTH(DEPTH), .VIEW(VIEW), .CNT_W(8)) dut (
        .slow_clk(slow_clk), .reset_n(reset_n), .load(load), .song_in(song_in),
        .run(run), .hit(hit), .view_out(view_out), .hit_ok(hit_ok), .miss(miss),
        .steps_left(steps_left), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
        .state_o(state_o)
    );

    note_lane_buffer #(.LANES(LANES), .DEPTH(DEPTH), .VIEW(VIEW), .CNT_W(2)) dut2 (
        .slow_clk(slow_clk), .reset_n(reset_n), .load(load2), .song_in(song2),
        .run(run2), .hit(hit2), .view_out(view2), .hit_ok(hit_ok2), .miss(miss2),
        .steps_left(steps2), .hit_cnt(hit_cnt2), .miss_cnt(miss_cnt2),
        .state_o(state2)
    );

    task automatic tick();
        @(posedge slow_clk);
        #1;
    endtask

    task automatic do_load(input logic [LANES*DEPTH-1:0] s);
        song_in = s;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++;
        if (state_o !== 2'd0 || view_out !== '0 || steps_left !== '0 ||
            hit_cnt !== 8'd0 || miss_cnt !== 8'd0 || hit_ok !== 3'b0 || miss !== 3'b0) begin
            failures++;
            $display("FAIL reset: state=%0d view=%h steps=%0d hc=%0d mc=%0d ok=%b miss=%b (want all 0)",
                     state_o, view_out, steps_left, hit_cnt, miss_cnt, hit_ok, miss);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_miss();
        logic [LANES*DEPTH-1:0] s;
        logic [LANES*VIEW-1:0]  ev;
        s = '0; s[99] = 1'b1;
        ev = '0; ev[26] = 1'b1;
        hit = '0;
        do_load(s);
        checks++;
        if (state_o !== 2'd1 || steps_left !== SW'(100) || view_out !== ev) begin
            failures++;
            $display("FAIL load_state: state=%0d steps=%0d view=%h (want 1 100 %h)", state_o, steps_left, view_out, ev);
        end
        run = 1'b1;
        tick();
        checks++;
        if (state_o !== 2'd2 || steps_left !== SW'(100) || miss !== 3'b0) begin
            failures++;
            $display("FAIL enter_play: state=%0d steps=%0d miss=%b (want 2 100 000)", state_o, steps_left, miss);
        end
        tick();
        checks++;
        if (miss !== 3'b001 || hit_ok !== 3'b000 || miss_cnt !== 8'd1 || steps_left !== SW'(99) || view_out !== '0) begin
            failures++;
            $display("FAIL first_miss: miss=%b ok=%b mc=%0d steps=%0d view=%h (want 001 000 1 99 0)",
                     miss, hit_ok, miss_cnt, steps_left, view_out);
        end
        tick();
        checks++;
        if (miss !== 3'b000 || miss_cnt !== 8'd1 || steps_left !== SW'(98)) begin
            failures++;
            $display("FAIL miss_pulse_width: miss=%b mc=%0d steps=%0d (want 000 1 98)", miss, miss_cnt, steps_left);
        end
        run = 1'b0;
    endtask

    task automatic test_hit();
        logic [LANES*DEPTH-1:0] s;
        s = '0; s[99] = 1'b1;
        do_load(s);
        run = 1'b1;
        tick();
        hit = 3'b001;
        tick();
        hit = 3'b000;
        checks++;
        if (hit_ok !== 3'b001 || miss !== 3'b000 || hit_cnt !== 8'd1 || miss_cnt !== 8'd0) begin
            failures++;
            $display("FAIL lane0_hit: ok=%b miss=%b hc=%0d mc=%0d (want 001 000 1 0)", hit_ok, miss, hit_cnt, miss_cnt);
        end
        tick();
        checks++;
        if (hit_ok !== 3'b000) begin
            failures++;
            $display("FAIL hit_pulse_width: ok=%b (want 000)", hit_ok);
        end
        do_load(s);
        tick();
        hit = 3'b010;
        tick();
        hit = 3'b000;
        checks++;
        if (miss !== 3'b001 || hit_ok !== 3'b000 || hit_cnt !== 8'd0 || miss_cnt !== 8'd1) begin
            failures++;
            $display("FAIL wrong_lane: miss=%b ok=%b hc=%0d mc=%0d (want 001 000 0 1)", miss, hit_ok, hit_cnt, miss_cnt);
        end
        run = 1'b0;
    endtask

    task automatic test_all_lanes();
        logic [LANES*DEPTH-1:0] s;
        s = '0; s[99] = 1'b1; s[199] = 1'b1; s[299] = 1'b1;
        do_load(s);
        run = 1'b1;
        tick();
        hit = 3'b111;
        tick();
        hit = 3'b000;
        checks++;
        if (hit_ok !== 3'b111 || miss !== 3'b000 || hit_cnt !== 8'd3 || miss_cnt !== 8'd0) begin
            failures++;
            $display("FAIL all_lanes: ok=%b miss=%b hc=%0d mc=%0d (want 111 000 3 0)", hit_ok, miss, hit_cnt, miss_cnt);
        end
        run = 1'b0;
    endtask

    task automatic test_pause();
        logic [LANES*DEPTH-1:0] s;
        logic [LANES*VIEW-1:0]  ev;
        int bad;
        s = '0; s[DEPTH + 80] = 1'b1;
        ev = '0; ev[VIEW + 17] = 1'b1;
        do_load(s);
        run = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        run = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (state_o !== 2'd1 || steps_left !== SW'(90) || view_out !== ev) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL pause_hold: %0d bad cycles, last state=%0d steps=%0d view=%h (want 1 90 %h)",
                     bad, state_o, steps_left, view_out, ev);
        end
        run = 1'b1;
        tick();
        for (int i = 0; i < 89; i++) tick();
        checks++;
        if (state_o !== 2'd2 || steps_left !== SW'(1)) begin
            failures++;
            $display("FAIL before_done: state=%0d steps=%0d (want 2 1)", state_o, steps_left);
        end
        tick();
        checks++;
        if (state_o !== 2'd3 || steps_left !== SW'(0) || view_out !== '0 || miss_cnt !== 8'd1) begin
            failures++;
            $display("FAIL done: state=%0d steps=%0d view=%h mc=%0d (want 3 0 0 1)", state_o, steps_left, view_out, miss_cnt);
        end
        hit = 3'b111;
        tick(); tick();
        hit = 3'b000;
        checks++;
        if (state_o !== 2'd3 || steps_left !== SW'(0) || hit_ok !== 3'b0 || hit_cnt !== 8'd0) begin
            failures++;
            $display("FAIL done_hold: state=%0d steps=%0d ok=%b hc=%0d (want 3 0 000 0)", state_o, steps_left, hit_ok, hit_cnt);
        end
        run = 1'b0;
    endtask

    task automatic test_load_override();
        logic [LANES*DEPTH-1:0] s;
        s = '0; s[99] = 1'b1; s[98] = 1'b1;
        do_load(s);
        run = 1'b1;
        tick();
        hit = 3'b001;
        tick();
        checks++;
        if (hit_cnt !== 8'd1 || hit_ok !== 3'b001) begin
            failures++;
            $display("FAIL pre_override: hc=%0d ok=%b (want 1 001)", hit_cnt, hit_ok);
        end
        song_in = s;
        load = 1'b1;
        tick();
        load = 1'b0;
        hit = 3'b000;
        checks++;
        if (hit_ok !== 3'b0 || miss !== 3'b0 || steps_left !== SW'(100) || state_o !== 2'd1 ||
            hit_cnt !== 8'd0 || miss_cnt !== 8'd0) begin
            failures++;
            $display("FAIL load_override: ok=%b miss=%b steps=%0d state=%0d hc=%0d mc=%0d (want 000 000 100 1 0 0)",
                     hit_ok, miss, steps_left, state_o, hit_cnt, miss_cnt);
        end
        run = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [LANES*DEPTH-1:0] s;
        s = '0; s[99] = 1'b1; s[98] = 1'b1;
        do_load(s);
        run = 1'b1;
        tick();
        tick();
        checks++;
        if (miss !== 3'b001 || state_o !== 2'd2) begin
            failures++;
            $display("FAIL pre_reset: miss=%b state=%0d (want 001 2)", miss, state_o);
        end
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (miss !== 3'b0 || hit_ok !== 3'b0 || state_o !== 2'd0 || steps_left !== '0 ||
            view_out !== '0 || miss_cnt !== 8'd0) begin
            failures++;
            $display("FAIL async_reset: miss=%b ok=%b state=%0d steps=%0d view=%h mc=%0d (want all 0)",
                     miss, hit_ok, state_o, steps_left, view_out, miss_cnt);
        end
        #1 reset_n = 1'b1;
        hit = 3'b001;
        tick(); tick();
        hit = 3'b000;
        checks++;
        if (miss !== 3'b0 || hit_ok !== 3'b0 || state_o !== 2'd0 || hit_cnt !== 8'd0) begin
            failures++;
            $display("FAIL post_reset_idle: miss=%b ok=%b state=%0d hc=%0d (want 000 000 0 0)", miss, hit_ok, state_o, hit_cnt);
        end
        run = 1'b0;
    endtask

    task automatic test_saturate();
        int bad;
        int exp;
        song2 = '0;
        song2[DEPTH-1:0] = '1;
        load2 = 1'b1;
        tick();
        load2 = 1'b0;
        run2 = 1'b1;
        tick();
        bad = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp = (k > 3) ? 3 : k;
            if (miss_cnt2 !== 2'(exp) || miss2 !== 3'b001) bad++;
        end
        checks++;
        if (bad != 0 || miss_cnt2 !== 2'd3) begin
            failures++;
            $display("FAIL saturate: %0d bad steps, mc=%0d miss=%b (want 3 001)", bad, miss_cnt2, miss2);
        end
        run2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_miss();
        test_hit();
        test_all_lanes();
        test_pause();
        test_load_override();
        test_async_reset();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
